// File: rtl/hidden_layer_seq.sv
// Time-multiplexed MLP hidden layer: LANES MAC lanes sweep HIDDEN_SIZE neurons in groups,
// then apply optional saturation and ReLU; the result vector is offered on a valid/ready handshake.
module hidden_layer_seq #(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 24,
    parameter int IN_DIM      = 16,
    parameter int HIDDEN_SIZE = 8,
    parameter int LANES       = 4,
    parameter bit RELU_EN     = 1'b1,
    parameter bit SAT_EN      = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [DATA_W*IN_DIM-1:0]            bus_in,
    input  logic [DATA_W*HIDDEN_SIZE*IN_DIM-1:0] weight_flat,
    input  logic [ACC_W*HIDDEN_SIZE-1:0]        bias_flat,
    output logic                                busy,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ACC_W*HIDDEN_SIZE-1:0]        hidden_out_flat
);

    localparam int GROUPS = HIDDEN_SIZE / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int KW     = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int PW     = 2 * DATA_W;
    localparam int AW     = ACC_W + 2 * DATA_W + $clog2(IN_DIM) + 1;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    if (HIDDEN_SIZE % LANES != 0) begin : g_lanes_check
        $error("HIDDEN_SIZE must be a multiple of LANES");
    end

    typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

    state_t state, state_next;

    logic signed [DATA_W-1:0] w_arr    [GROUPS][LANES][IN_DIM];
    logic signed [ACC_W-1:0]  bias_arr [GROUPS][LANES];
    logic        [ACC_W-1:0]  out_reg  [GROUPS][LANES];
    logic signed [DATA_W-1:0] in_reg   [IN_DIM];
    logic signed [AW-1:0]     acc      [LANES];
    logic signed [PW-1:0]     prod     [LANES];
    logic [GW-1:0]            g;
    logic [KW-1:0]            k;
    logic                     start_d;
    logic                     start_pulse;
    logic                     k_last;
    logic                     g_last;

    // Regroup flat buses by [group][lane] so neuron n lives at [n/LANES][n%LANES].
    for (genvar n = 0; n < HIDDEN_SIZE; n++) begin : g_unpack
        assign bias_arr[n/LANES][n%LANES] = bias_flat[n*ACC_W +: ACC_W];
        assign hidden_out_flat[n*ACC_W +: ACC_W] = out_reg[n/LANES][n%LANES];
        for (genvar j = 0; j < IN_DIM; j++) begin : g_w
            assign w_arr[n/LANES][n%LANES][j] = weight_flat[(n*IN_DIM+j)*DATA_W +: DATA_W];
        end
    end

    assign start_pulse = start & ~start_d;
    assign k_last      = (k == KW'(IN_DIM - 1));
    assign g_last      = (g == GW'(GROUPS - 1));

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            prod[l] = PW'(w_arr[g][l][k]) * PW'(in_reg[k]);
        end
    end

    function automatic logic [ACC_W-1:0] activate(input logic signed [AW-1:0] a);
        logic [ACC_W-1:0] r;
        if (SAT_EN && (a > SAT_MAX)) begin
            r = SAT_MAX[ACC_W-1:0];
        end else if (SAT_EN && (a < SAT_MIN)) begin
            r = SAT_MIN[ACC_W-1:0];
        end else begin
            r = a[ACC_W-1:0];
        end
        if (RELU_EN && r[ACC_W-1]) begin
            r = '0;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: if (start_pulse) state_next = MAC;
            MAC: begin
                busy = 1'b1;
                if (k_last) state_next = ACT;
            end
            ACT: begin
                busy       = 1'b1;
                state_next = g_last ? DONE : MAC;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_d <= 1'b0;
            g       <= '0;
            k       <= '0;
            for (int unsigned l = 0; l < LANES; l++) acc[l] <= '0;
            for (int unsigned i = 0; i < IN_DIM; i++) in_reg[i] <= '0;
            for (int unsigned gi = 0; gi < GROUPS; gi++) begin
                for (int unsigned l = 0; l < LANES; l++) out_reg[gi][l] <= '0;
            end
        end else begin
            start_d <= start;
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        for (int unsigned i = 0; i < IN_DIM; i++) begin
                            in_reg[i] <= bus_in[i*DATA_W +: DATA_W];
                        end
                        g <= '0;
                        k <= '0;
                        for (int unsigned l = 0; l < LANES; l++) acc[l] <= AW'(bias_arr[0][l]);
                    end
                end
                MAC: begin
                    for (int unsigned l = 0; l < LANES; l++) acc[l] <= acc[l] + AW'(prod[l]);
                    k <= k_last ? '0 : k + 1'b1;
                end
                ACT: begin
                    for (int unsigned l = 0; l < LANES; l++) out_reg[g][l] <= activate(acc[l]);
                    // Bias of the next group is preloaded here so MAC restarts without a bubble.
                    if (!g_last) begin
                        g <= g + 1'b1;
                        k <= '0;
                        for (int unsigned l = 0; l < LANES; l++) begin
                            acc[l] <= AW'(bias_arr[g + 1'b1][l]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_layer_seq.sv
// Directed bench for hidden_layer_seq: five parameter variants share one stimulus set
// and are checked against hand-computed results, latencies and handshake behaviour.
module tb_hidden_layer_seq;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int IN_DIM = 16;
    localparam int HS     = 8;
    localparam int NI     = 5;
    localparam int OW     = ACC_W * HS;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic                        out_ready;
    logic [DATA_W*IN_DIM-1:0]    bus_in;
    logic [DATA_W*HS*IN_DIM-1:0] weight_flat;
    logic [OW-1:0]               bias_flat;
    logic                        busy [NI];
    logic                        ov   [NI];
    logic [OW-1:0]               ho   [NI];

    int tests = 0;
    int fails = 0;
    int lat  [NI];
    int vcnt [NI];
    // Variants: 0 defaults, 1 no ReLU, 2 no ReLU/no saturation, 3 LANES=1, 4 LANES=8
    int exp_lat [NI] = '{34, 34, 34, 136, 17};

    always #5 clk = ~clk;

    hidden_layer_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IN_DIM(IN_DIM), .HIDDEN_SIZE(HS),
                       .LANES(4), .RELU_EN(1'b1), .SAT_EN(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .bus_in(bus_in), .weight_flat(weight_flat),
        .bias_flat(bias_flat), .busy(busy[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .hidden_out_flat(ho[0]));
    hidden_layer_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IN_DIM(IN_DIM), .HIDDEN_SIZE(HS),
                       .LANES(4), .RELU_EN(1'b0), .SAT_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .bus_in(bus_in), .weight_flat(weight_flat),
        .bias_flat(bias_flat), .busy(busy[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .hidden_out_flat(ho[1]));
    hidden_layer_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IN_DIM(IN_DIM), .HIDDEN_SIZE(HS),
                       .LANES(4), .RELU_EN(1'b0), .SAT_EN(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .bus_in(bus_in), .weight_flat(weight_flat),
        .bias_flat(bias_flat), .busy(busy[2]), .out_valid(ov[2]), .out_ready(out_ready),
        .hidden_out_flat(ho[2]));
    hidden_layer_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IN_DIM(IN_DIM), .HIDDEN_SIZE(HS),
                       .LANES(1), .RELU_EN(1'b1), .SAT_EN(1'b1)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .bus_in(bus_in), .weight_flat(weight_flat),
        .bias_flat(bias_flat), .busy(busy[3]), .out_valid(ov[3]), .out_ready(out_ready),
        .hidden_out_flat(ho[3]));
    hidden_layer_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .IN_DIM(IN_DIM), .HIDDEN_SIZE(HS),
                       .LANES(8), .RELU_EN(1'b1), .SAT_EN(1'b1)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .bus_in(bus_in), .weight_flat(weight_flat),
        .bias_flat(bias_flat), .busy(busy[4]), .out_valid(ov[4]), .out_ready(out_ready),
        .hidden_out_flat(ho[4]));

    task automatic set_uniform(input logic [7:0] w, input logic [7:0] x, input logic [23:0] b);
        weight_flat = {(HS*IN_DIM){w}};
        bus_in      = {IN_DIM{x}};
        bias_flat   = {HS{b}};
    endtask

    // Pulses (or holds) start, then records per-variant first-valid cycle and valid count.
    task automatic launch(input bit hold, input int ncyc);
        for (int i = 0; i < NI; i++) begin
            lat[i]  = -1;
            vcnt[i] = 0;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                if (ov[i] === 1'b1) begin
                    if (lat[i] < 0) lat[i] = c;
                    vcnt[i]++;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic drain();
        int  c;
        bit  idle;
        out_ready = 1'b1;
        start     = 1'b0;
        for (c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            idle = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (busy[i] !== 1'b0 || ov[i] !== 1'b0) idle = 1'b0;
            end
            if (idle) break;
        end
        tests++;
        if (c >= 400) begin
            fails++;
            $display("FAIL drain: still active after %0d cycles, required idle", c);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        set_uniform(8'd0, 8'd0, 24'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (busy[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset_busy inst%0d: got %b, required 0", i, busy[i]);
            end
            tests++;
            if (ov[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset_valid inst%0d: got %b, required 0", i, ov[i]);
            end
            tests++;
            if (ho[i] !== '0) begin
                fails++;
                $display("FAIL reset_out inst%0d: got %h, required 0", i, ho[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        set_uniform(8'd1, 8'd2, 24'd5);
        launch(1'b0, 150);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (lat[i] !== exp_lat[i]) begin
                fails++;
                $display("FAIL basic_latency inst%0d: got %0d, required %0d", i, lat[i], exp_lat[i]);
            end
            tests++;
            if (vcnt[i] !== 1) begin
                fails++;
                $display("FAIL basic_valid_cycles inst%0d: got %0d, required 1", i, vcnt[i]);
            end
            tests++;
            if (ho[i] !== {HS{24'd37}}) begin
                fails++;
                $display("FAIL basic_out inst%0d: got %h, required %h", i, ho[i], {HS{24'd37}});
            end
        end
    endtask

    task automatic test_relu();
        logic [23:0] e [NI] = '{24'd0, 24'hFFFFDA, 24'hFFFFDA, 24'd0, 24'd0};
        set_uniform(8'hFF, 8'd3, 24'd10);
        launch(1'b0, 150);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (ho[i] !== {HS{e[i]}}) begin
                fails++;
                $display("FAIL relu_out inst%0d: got %h, required %h", i, ho[i], {HS{e[i]}});
            end
        end
    endtask

    task automatic test_sat();
        logic [23:0] e [NI] = '{24'h7FFFFF, 24'h7FFFFF, 24'h83F00F, 24'h7FFFFF, 24'h7FFFFF};
        set_uniform(8'd127, 8'd127, 24'h7FFFFF);
        launch(1'b0, 150);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (ho[i] !== {HS{e[i]}}) begin
                fails++;
                $display("FAIL sat_out inst%0d: got %h, required %h", i, ho[i], {HS{e[i]}});
            end
        end
    endtask

    // Distinct per-neuron weights/bias and per-input values expose lane/group/k mapping.
    task automatic test_mapping();
        int            map_exp [HS] = '{136, 372, 608, 844, 1080, 1316, 1552, 1788};
        logic [OW-1:0] ev;
        for (int n = 0; n < HS; n++) begin
            bias_flat[n*ACC_W +: ACC_W] = 24'(n * 100);
            ev[n*ACC_W +: ACC_W]        = 24'(map_exp[n]);
            for (int k = 0; k < IN_DIM; k++) begin
                weight_flat[(n*IN_DIM+k)*DATA_W +: DATA_W] = 8'(n + 1);
            end
        end
        for (int k = 0; k < IN_DIM; k++) bus_in[k*DATA_W +: DATA_W] = 8'(k + 1);
        launch(1'b0, 150);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (ho[i] !== ev) begin
                fails++;
                $display("FAIL mapping_out inst%0d: got %h, required %h", i, ho[i], ev);
            end
        end
    endtask

    task automatic test_backpressure();
        bit found = 1'b0;
        set_uniform(8'd2, 8'd1, 24'hFFFFFD);
        out_ready = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (ov[0] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL bp_valid_rise: got no out_valid within 60 cycles, required rise");
        end
        for (int c = 0; c < 20; c++) begin
            if (c == 3 || c == 10) start = 1'b1;
            if (c == 4 || c == 12) start = 1'b0;
            @(posedge clk); #1;
            tests++;
            if (ov[0] !== 1'b1 || ho[0] !== {HS{24'd29}}) begin
                fails++;
                $display("FAIL bp_hold cycle%0d: got valid=%b out=%h, required valid=1 out=%h",
                         c, ov[0], ho[0], {HS{24'd29}});
            end
        end
        out_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (ov[0] !== 1'b0 || busy[0] !== 1'b0 || ho[0] !== {HS{24'd29}}) begin
            fails++;
            $display("FAIL bp_accept: got valid=%b busy=%b out=%h, required valid=0 busy=0 out=%h",
                     ov[0], busy[0], ho[0], {HS{24'd29}});
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests++;
            if (busy[0] !== 1'b0 || ov[0] !== 1'b0) begin
                fails++;
                $display("FAIL bp_no_restart cycle%0d: got busy=%b valid=%b, required 0 0",
                         c, busy[0], ov[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_uniform(8'd1, 8'd2, 24'd5);
        out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (busy[i] !== 1'b0 || ov[i] !== 1'b0 || ho[i] !== '0) begin
                fails++;
                $display("FAIL midreset_clear inst%0d: got busy=%b valid=%b out=%h, required 0 0 0",
                         i, busy[i], ov[i], ho[i]);
            end
        end
        launch(1'b0, 150);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (lat[i] !== exp_lat[i] || ho[i] !== {HS{24'd37}}) begin
                fails++;
                $display("FAIL midreset_rerun inst%0d: got lat=%0d out=%h, required lat=%0d out=%h",
                         i, lat[i], ho[i], exp_lat[i], {HS{24'd37}});
            end
        end
    endtask

    task automatic test_start_held();
        set_uniform(8'd3, 8'hFE, 24'd100);
        launch(1'b1, 150);
        for (int i = 0; i < NI; i++) begin
            tests++;
            if (vcnt[i] !== 1 || lat[i] !== exp_lat[i]) begin
                fails++;
                $display("FAIL held_single_run inst%0d: got runs=%0d lat=%0d, required runs=1 lat=%0d",
                         i, vcnt[i], lat[i], exp_lat[i]);
            end
            tests++;
            if (ho[i] !== {HS{24'd4}}) begin
                fails++;
                $display("FAIL held_out inst%0d: got %h, required %h", i, ho[i], {HS{24'd4}});
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        drain();
        test_relu();
        drain();
        test_sat();
        drain();
        test_mapping();
        drain();
        test_backpressure();
        drain();
        test_reset_mid();
        drain();
        test_start_held();
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
